// File: rtl/regfile_access_ctrl_pkg.sv
// rtl/regfile_access_ctrl_pkg.sv - shared types and default widths for the regfile access controller
package regfile_access_ctrl_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_RD_LAT = 1;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_CLEAR   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_CLR,
        ST_RESP
    } state_e;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// rtl/regfile_access_ctrl_if.sv - command/response channel bundle for the regfile access controller
interface regfile_access_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    // Front end issuing commands and consuming responses
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    // Controller accepting commands and producing responses
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - sequences READ/WRITE/CLEAR commands onto a register-file port
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    regfile_access_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] rf_read_addr,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_en,
    input  logic [DATA_W-1:0] rf_read_data
);

    // One bit wider than the address so DEPTH == 2**ADDR_W never wraps
    localparam logic [ADDR_W:0]   CLR_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [1:0]        RD_LAST  = 2'(RD_LAT);
    localparam logic [DATA_W-1:0] CLR_RSP  = DATA_W'(DEPTH);

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic [1:0]        rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
    logic [ADDR_W:0]   clr_cnt_inc;

    assign clr_cnt_inc = clr_cnt_q + 1'b1;

    // Every output is a flop; reset parks the FSM in IDLE with all outputs low
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            rd_cnt_q    <= '0;
            clr_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            rd_cnt_q    <= rd_cnt_d;
            clr_cnt_q   <= clr_cnt_d;
        end
    end

    // Next-state and next-output decode; registers hold unless a state changes them
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        rd_cnt_d    = rd_cnt_q;
        clr_cnt_d   = clr_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    unique case (op_e'(bus.cmd_op))
                        OP_READ: begin
                            rd_addr_d = bus.cmd_addr;
                            rd_cnt_d  = '0;
                            state_d   = ST_RD;
                        end
                        OP_WRITE: begin
                            wr_addr_d = bus.cmd_addr;
                            wr_data_d = bus.cmd_wdata;
                            wr_en_d   = 1'b1;
                            state_d   = ST_WR;
                        end
                        OP_CLEAR: begin
                            clr_cnt_d = '0;
                            wr_addr_d = '0;
                            wr_data_d = '0;
                            wr_en_d   = 1'b1;
                            state_d   = ST_CLR;
                        end
                        OP_ILLEGAL: begin
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                            rsp_data_d  = '0;
                            state_d     = ST_RESP;
                        end
                    endcase
                end
            end
            ST_RD: begin
                if (rd_cnt_q == RD_LAST) begin
                    rsp_data_d  = rf_read_data;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                end
            end
            ST_WR: begin
                rsp_data_d  = wr_data_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_CLR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    rsp_data_d  = CLR_RSP;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    clr_cnt_d = clr_cnt_inc;
                    wr_addr_d = clr_cnt_inc[ADDR_W-1:0];
                    wr_en_d   = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    assign rf_read_addr  = rd_addr_q;
    assign rf_write_addr = wr_addr_q;
    assign rf_write_data = wr_data_q;
    assign rf_write_en   = wr_en_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb/tb_regfile_access_ctrl.sv - directed self-checking bench for regfile_access_ctrl
module tb_regfile_access_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  rf_read_addr;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        rf_write_en;
    logic [31:0] rf_read_data;

    logic [31:0] mem [32];

    int checks;
    int errors;

    regfile_access_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_access_ctrl #(
        .ADDR_W(5),
        .DATA_W(32),
        .DEPTH (32),
        .RD_LAT(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .rf_read_addr (rf_read_addr),
        .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .rf_write_en  (rf_write_en),
        .rf_read_data (rf_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model with one cycle of read latency
    always @(posedge clk) begin
        if (rf_write_en) mem[rf_write_addr] <= rf_write_data;
        rf_read_data <= mem[rf_read_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] data, output logic err);
        int w;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait: got %b expected 1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        step();
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_wait: got rsp_valid=%b expected 1", bus.rsp_valid);
        end
        data = bus.rsp_data;
        err  = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", bus.cmd_ready); end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsp: got valid=%b err=%b data=%h expected 0 0 0", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
        checks++;
        if (rf_write_en !== 1'b0 || rf_read_addr !== 5'd0 || rf_write_addr !== 5'd0 || rf_write_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rf: got en=%b ra=%h wa=%h wd=%h expected all 0", rf_write_en, rf_read_addr, rf_write_addr, rf_write_data);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.cmd_ready); end
    endtask

    task automatic test_write();
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_addr  = 5'd0;
        bus.cmd_wdata = 32'hffff;
        step();
        bus.cmd_valid = 1'b0;
        checks++;
        if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd0 || rf_write_data !== 32'hffff || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_port: got en=%b wa=%h wd=%h rv=%b expected 1 00 0000ffff 0", rf_write_en, rf_write_addr, rf_write_data, bus.rsp_valid);
        end
        step();
        checks++;
        if (rf_write_en !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hffff || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL write_rsp: got en=%b rv=%b rd=%h re=%b expected 0 1 0000ffff 0", rf_write_en, bus.rsp_valid, bus.rsp_data, bus.rsp_err);
        end
        step();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_done: got rv=%b cr=%b expected 0 1", bus.rsp_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] d;
        logic e;
        do_cmd(2'b01, 5'd2, 32'hfffc, lat, d, e);
        checks++;
        if (lat != 2 || d !== 32'hfffc || e !== 1'b0) begin errors++; $display("FAIL wr2: got lat=%0d data=%h err=%b expected 2 0000fffc 0", lat, d, e); end
        do_cmd(2'b01, 5'd31, 32'hfff0, lat, d, e);
        checks++;
        if (lat != 2 || d !== 32'hfff0 || e !== 1'b0) begin errors++; $display("FAIL wr31: got lat=%0d data=%h err=%b expected 2 0000fff0 0", lat, d, e); end
        do_cmd(2'b00, 5'd2, 32'h0, lat, d, e);
        checks++;
        if (lat != 3 || d !== 32'hfffc || e !== 1'b0) begin errors++; $display("FAIL rd2: got lat=%0d data=%h err=%b expected 3 0000fffc 0", lat, d, e); end
        do_cmd(2'b00, 5'd31, 32'h0, lat, d, e);
        checks++;
        if (lat != 3 || d !== 32'hfff0 || e !== 1'b0) begin errors++; $display("FAIL rd31: got lat=%0d data=%h err=%b expected 3 0000fff0 0", lat, d, e); end
        do_cmd(2'b00, 5'd0, 32'h0, lat, d, e);
        checks++;
        if (d !== 32'hffff) begin errors++; $display("FAIL rd0: got %h expected 0000ffff", d); end
    endtask

    task automatic test_clear();
        int lat;
        int n;
        int bad;
        logic [31:0] d;
        logic e;
        n = 0;
        bad = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        bus.cmd_addr  = 5'd7;
        bus.cmd_wdata = 32'hdeadbeef;
        step();
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 200) begin
            if (rf_write_en !== 1'b1 || rf_write_addr !== n[4:0] || rf_write_data !== 32'h0) bad++;
            if (rf_write_en === 1'b1) n++;
            step();
            lat++;
        end
        checks++;
        if (bad != 0 || n != 32) begin errors++; $display("FAIL clear_walk: got writes=%0d bad=%0d expected 32 0", n, bad); end
        checks++;
        if (lat != 33 || bus.rsp_data !== 32'd32 || bus.rsp_err !== 1'b0 || rf_write_en !== 1'b0) begin
            errors++;
            $display("FAIL clear_rsp: got lat=%0d data=%h err=%b en=%b expected 33 00000020 0 0", lat, bus.rsp_data, bus.rsp_err, rf_write_en);
        end
        step();
        do_cmd(2'b00, 5'd31, 32'h0, lat, d, e);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL clear_rd31: got %h expected 00000000", d); end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        logic [31:0] d;
        logic e;
        bad = 0;
        do_cmd(2'b01, 5'd5, 32'ha5a5, lat, d, e);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 5'd5;
        step();
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
        checks++;
        if (lat != 3 || bus.rsp_data !== 32'ha5a5) begin errors++; $display("FAIL bp_first: got lat=%0d data=%h expected 3 0000a5a5", lat, bus.rsp_data); end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_addr  = 5'd5;
        bus.cmd_wdata = 32'hdead;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'ha5a5 || bus.cmd_ready !== 1'b0 || rf_write_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got rv=%b cr=%b expected 0 1", bus.rsp_valid, bus.cmd_ready);
        end
        do_cmd(2'b00, 5'd5, 32'h0, lat, d, e);
        checks++;
        if (d !== 32'ha5a5) begin errors++; $display("FAIL bp_ignored_write: got %h expected 0000a5a5", d); end
    endtask

    task automatic test_illegal();
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b11;
        bus.cmd_addr  = 5'd9;
        bus.cmd_wdata = 32'h1111;
        step();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'h0 || rf_write_en !== 1'b0) begin
            errors++;
            $display("FAIL illegal_rsp: got rv=%b err=%b data=%h en=%b expected 1 1 0 0", bus.rsp_valid, bus.rsp_err, bus.rsp_data, rf_write_en);
        end
        step();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || rf_write_en !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_done: got rv=%b err=%b en=%b cr=%b expected 0 0 0 1", bus.rsp_valid, bus.rsp_err, rf_write_en, bus.cmd_ready);
        end
    endtask

    task automatic test_reset_during_clear();
        int lat;
        int w;
        int seen;
        logic [31:0] d;
        logic e;
        seen = 0;
        do_cmd(2'b01, 5'd31, 32'h1234, lat, d, e);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        step();
        bus.cmd_valid = 1'b0;
        w = 0;
        while (!(rf_write_en === 1'b1 && rf_write_addr === 5'd10) && w < 50) begin
            step();
            w++;
        end
        checks++;
        if (rf_write_addr !== 5'd10) begin errors++; $display("FAIL rstclr_reach: got addr=%h expected 0a", rf_write_addr); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (rf_write_en !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstclr_abort: got en=%b rv=%b cr=%b expected 0 0 0", rf_write_en, bus.rsp_valid, bus.cmd_ready);
        end
        step();
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstclr_ready: got %b expected 1", bus.cmd_ready); end
        for (int i = 0; i < 40; i++) begin
            if (bus.rsp_valid === 1'b1 || rf_write_en === 1'b1) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rstclr_quiet: got %0d active cycles expected 0", seen); end
        do_cmd(2'b00, 5'd31, 32'h0, lat, d, e);
        checks++;
        if (d !== 32'h1234) begin errors++; $display("FAIL rstclr_rd31: got %h expected 00001234", d); end
        do_cmd(2'b00, 5'd3, 32'h0, lat, d, e);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rstclr_rd3: got %h expected 00000000", d); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 5'd0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_write();
        test_back_to_back();
        test_clear();
        test_backpressure();
        test_illegal();
        test_reset_during_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
